// File: rtl/opcode_decode_pkg.sv
// Shared opfunc encoding for the decode stage: source-select constants,
// instruction field offsets and the 7-bit opfunc type.
package opcode_decode_pkg;

    localparam int OPFUNC_W = 7;
    localparam int FIELD_W  = 6;
    localparam int OP_LSB   = 26;
    localparam int FUNC_LSB = 0;

    localparam logic SRC_OP   = 1'b1;
    localparam logic SRC_FUNC = 1'b0;

    typedef logic [OPFUNC_W-1:0] opfunc_t;

endpackage

// File: rtl/opcode_lane_decode.sv
// Combinational single-lane classifier: 32-bit word plus mask bit -> opfunc.
module opcode_lane_decode
    import opcode_decode_pkg::*;
(
    input  logic [31:0] inst,
    input  logic        mask,
    output logic [6:0]  opfunc
);

    logic [FIELD_W-1:0] op;
    logic [FIELD_W-1:0] func;
    logic               unused_mid_bits;

    assign op              = inst[OP_LSB +: FIELD_W];
    assign func            = inst[FUNC_LSB +: FIELD_W];
    assign unused_mid_bits = ^inst[OP_LSB-1:FUNC_LSB+FIELD_W];

    // NOTE: assign a default first so every path through always_comb drives opfunc (no latch).
    always_comb begin
        opfunc = '0;
        if (mask) begin
            if (op != '0) opfunc = {SRC_OP, op};
            else          opfunc = {SRC_FUNC, func};
        end
    end

endmodule

// File: rtl/opcode_decode_stage.sv
// Registered multi-lane decode stage with valid/ready handshake and flush.
// Define OPCODE_DECODE_SKID_EN for a skid entry and a registered in_ready.
module opcode_decode_stage
    import opcode_decode_pkg::*;
#(
    parameter int LANES = 2,
    parameter int PC_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*32-1:0]       in_inst,
    input  logic [LANES-1:0]          in_mask,
    input  logic [PC_W-1:0]           in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*OPFUNC_W-1:0] out_opfunc,
    output logic [LANES*32-1:0]       out_inst,
    output logic [LANES-1:0]          out_mask,
    output logic [PC_W-1:0]           out_pc
);

    typedef struct packed {
        logic [LANES*OPFUNC_W-1:0] opfunc;
        logic [LANES*32-1:0]       inst;
        logic [LANES-1:0]          mask;
        logic [PC_W-1:0]           pc;
    } bundle_t;

    bundle_t                   in_bundle;
    bundle_t                   main_d, main_q;
    logic                      main_valid_d, main_valid_q;
    logic [LANES*OPFUNC_W-1:0] dec_opfunc;
    logic                      accept;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        opcode_lane_decode u_lane (
            .inst   (in_inst[32*i +: 32]),
            .mask   (in_mask[i]),
            .opfunc (dec_opfunc[OPFUNC_W*i +: OPFUNC_W])
        );
    end

    assign in_bundle = '{opfunc: dec_opfunc, inst: in_inst, mask: in_mask, pc: in_pc};
    assign accept    = in_valid & in_ready;

`ifdef OPCODE_DECODE_SKID_EN
    bundle_t skid_d, skid_q;
    logic    skid_valid_d, skid_valid_q;
    logic    in_ready_d, in_ready_q;

    assign in_ready = in_ready_q;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // Main is necessarily full here; drain the skid entry without a bubble.
            if (out_ready) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || out_ready) begin
                main_d       = in_bundle;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = in_bundle;
                skid_valid_d = 1'b1;
            end
        end else if (out_ready) begin
            main_valid_d = 1'b0;
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    assign in_ready = out_ready | ~main_valid_q;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (accept) begin
            main_d       = in_bundle;
            main_valid_d = 1'b1;
        end else if (out_ready) begin
            main_valid_d = 1'b0;
        end
    end
`endif

    // NOTE: the data payload is reset too, because the outputs must read zero after reset.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
        end
    end

    assign out_valid  = main_valid_q;
    assign out_opfunc = main_q.opfunc;
    assign out_inst   = main_q.inst;
    assign out_mask   = main_q.mask;
    assign out_pc     = main_q.pc;

endmodule

// File: tb/tb_opcode_decode_stage.sv
// Self-checking bench for opcode_decode_stage: vector table, corner sequences
// and random traffic against a queue-based reference model.
module tb_opcode_decode_stage;

    localparam int LANES = 2;
    localparam int PC_W  = 32;
`ifdef OPCODE_DECODE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*32-1:0]  in_inst;
    logic [LANES-1:0]     in_mask;
    logic [PC_W-1:0]      in_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*7-1:0]   out_opfunc;
    logic [LANES*32-1:0]  out_inst;
    logic [LANES-1:0]     out_mask;
    logic [PC_W-1:0]      out_pc;

    opcode_decode_stage #(.LANES(LANES), .PC_W(PC_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_mask    (in_mask),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opfunc (out_opfunc),
        .out_inst   (out_inst),
        .out_mask   (out_mask),
        .out_pc     (out_pc)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [LANES*7-1:0]  opfunc;
        logic [LANES*32-1:0] inst;
        logic [LANES-1:0]    mask;
        logic [PC_W-1:0]     pc;
    } bundle_t;

    typedef struct {
        logic [63:0] inst;
        logic [1:0]  mask;
        logic [13:0] exp_opfunc;
    } vec_t;

    bundle_t model_q[$];
    int      tests     = 0;
    int      failed    = 0;
    int      dut_emits = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Opfunc from the instruction-set rule: major opcode if nonzero, else function field.
    function automatic int unsigned ref_lane(logic [31:0] w, logic m);
        int unsigned op, func;
        op   = int'(w) >>> 26;
        op   = w / 32'd67108864;
        func = w % 64;
        if (!m)      return 0;
        if (op != 0) return 64 + op;
        return func;
    endfunction

    function automatic bundle_t ref_bundle(logic [63:0] inst, logic [1:0] mask, logic [31:0] pc);
        bundle_t b;
        b.inst   = inst;
        b.mask   = mask;
        b.pc     = pc;
        b.opfunc = 14'(ref_lane(inst[63:32], mask[1]) * 128 + ref_lane(inst[31:0], mask[0]));
        return b;
    endfunction

    task automatic cycle();
        bit exp_rdy, acc, emt;
        @(negedge clock);
        exp_rdy = SKID ? (model_q.size() < 2) : (out_ready || model_q.size() == 0);
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, model_q.size() != 0);
        if (model_q.size() != 0) begin
            check("out_opfunc", out_opfunc, model_q[0].opfunc);
            check("out_inst", out_inst, model_q[0].inst);
            check("out_mask", out_mask, model_q[0].mask);
            check("out_pc", out_pc, model_q[0].pc);
        end
        if (out_valid && out_ready) dut_emits++;
        acc = in_valid && exp_rdy;
        emt = out_ready && model_q.size() != 0;
        @(posedge clock);
        if (flush) begin
            model_q.delete();
        end else begin
            if (emt) void'(model_q.pop_front());
            if (acc) model_q.push_back(ref_bundle(in_inst, in_mask, in_pc));
        end
        #1;
    endtask

    task automatic check_zero_outputs(string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_opfunc"}, out_opfunc, 0);
        check({tag, "_out_inst"}, out_inst, 0);
        check({tag, "_out_mask"}, out_mask, 0);
        check({tag, "_out_pc"}, out_pc, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    task automatic drive(logic v, logic [63:0] inst, logic [1:0] mask, logic [31:0] pc);
        in_valid = v;
        in_inst  = inst;
        in_mask  = mask;
        in_pc    = pc;
    endtask

    initial begin
        vec_t       vecs[7];
        logic [31:0] stall_pc;
        int          emits_before;

        vecs[0] = '{{32'h8C820004, 32'h00851021}, 2'b11, {7'h63, 7'h21}};
        vecs[1] = '{{32'h00000000, 32'h00000000}, 2'b11, {7'h00, 7'h00}};
        vecs[2] = '{{32'h00000000, 32'h00000000}, 2'b00, {7'h00, 7'h00}};
        vecs[3] = '{{32'h8C820004, 32'h00851021}, 2'b01, {7'h00, 7'h21}};
        vecs[4] = '{{32'h00000008, 32'h08000010}, 2'b11, {7'h08, 7'h42}};
        vecs[5] = '{{32'hFC00003F, 32'h0000003F}, 2'b11, {7'h7F, 7'h3F}};
        vecs[6] = '{{32'hFFFFFFFF, 32'h24420001}, 2'b10, {7'h7F, 7'h00}};

        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, '0, '0, '0);
        #12;
        check_zero_outputs("reset");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;

        // Directed decode vectors, one bundle at a time.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, vecs[i].inst, vecs[i].mask, 32'h400 + 32'(i * 8));
            cycle();
            check($sformatf("vec%0d_opfunc", i), out_opfunc, vecs[i].exp_opfunc);
            check($sformatf("vec%0d_mask", i), out_mask, vecs[i].mask);
            check($sformatf("vec%0d_pc", i), out_pc, 32'h400 + 32'(i * 8));
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            drive(1'b0, '0, '0, '0);
            cycle();
        end

        // Stall for 5 cycles while upstream keeps streaming.
        out_ready = 1'b0;
        stall_pc  = 32'h2000;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, {$urandom, $urandom}, 2'(i + 1), 32'h2000 + 32'(i * 8));
            cycle();
        end
        check("stall_in_ready", in_ready, 0);
        check("stall_out_pc", out_pc, stall_pc);

        // Flush with main (and skid, if present) full and a live input.
        flush = 1'b1;
        drive(1'b1, 64'hDEADBEEF_DEADBEEF, 2'b11, 32'hDEAD0000);
        cycle();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // 100 back-to-back bundles with downstream always ready.
        emits_before = dut_emits;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, {$urandom, $urandom}, 2'($urandom), 32'h1000 + 32'(i * 8));
            cycle();
        end
        drive(1'b0, '0, '0, '0);
        cycle();
        check("stream_emits", dut_emits - emits_before, 100);

        // Random traffic including stalls and flushes.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 2'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) in_inst[63:58] = 6'd0;
            if ($urandom_range(0, 3) == 0) in_inst[31:26] = 6'd0;
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 31) == 0);
            cycle();
        end
        flush = 1'b0;

        // Asynchronous reset in the middle of a stalled stream.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, {$urandom, $urandom}, 2'b11, 32'h3000 + 32'(i * 8));
            cycle();
        end
        #2 reset = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        model_q.delete();
        drive(1'b0, '0, '0, '0);
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        drive(1'b1, vecs[0].inst, vecs[0].mask, 32'h400);
        cycle();
        check("post_reset_opfunc", out_opfunc, {7'h63, 7'h21});
        check("post_reset_pc", out_pc, 32'h400);
        drive(1'b0, '0, '0, '0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/opcode_decode_stage.md
# opcode_decode_stage

Registered, multi-lane decode stage between instruction fetch and register read in the pipelined MIPS core. Each cycle it accepts a bundle of up to `LANES` 32-bit instruction words and classifies each into a 7-bit opfunc code: the source bit plus the 6-bit op or func field. It holds the result in a valid/ready pipeline register with flush support. An optional skid buffer gives full throughput with a registered `in_ready`.

## Interface
- `LANES`, 2, instruction words per bundle (≥1)
- `PC_W`, 32, program-counter width
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `flush`  in  1  discard all held and incoming bundles
- `in_valid`  in  1  upstream bundle present
- `in_ready`  out  1  stage can accept
- `in_inst`  in  LANES*32  lane i at bits [32i+31:32i]
- `in_mask`  in  LANES  per-lane valid
- `in_pc`  in  PC_W  PC of lane 0; lane i implied PC = in_pc + 4i
- `out_valid`  out  1  output bundle present
- `out_ready`  in  1  downstream accepts
- `out_opfunc`  out  LANES*7  lane i at [7i+6:7i]
- `out_inst`  out  LANES*32  registered copy of in_inst
- `out_mask`  out  LANES  registered copy of in_mask
- `out_pc`  out  PC_W  registered in_pc

## Operation
- Accept when `in_valid & in_ready`. Emit when `out_valid & out_ready`.
- Per-lane decode for lane i with `op = inst[31:26]` and `func = inst[5:0]`:
  - `op != 0` → `{SRC_OP, op}`.
  - `op == 0` → `{SRC_FUNC, func}`.
  - `SRC_OP = 1'b1`, `SRC_FUNC = 1'b0`.
  - Masked-off lane (`in_mask[i]=0`) → opfunc `7'h00`. Its inst field is still copied.
- A bundle with `in_mask == 0` is still accepted and emitted (bubble bundle).
- Decode is combinational on the input side, and only registered values reach the outputs.
- While `out_valid & ~out_ready`, all outputs hold stable.
- `flush` at a rising edge:
  - clears `out_valid` and any skid entry;
  - an input transfer in the same cycle is consumed and discarded;
  - `flush` beats accept.
- Outputs at reset: `out_valid=0`, `out_opfunc=0`, `out_inst=0`, `out_mask=0`, `out_pc=0`, skid empty.
  - `in_ready=1` after reset in both configurations.
  - Reset mid-transfer drops everything with no partial bundle.

## Timing
- Latency 1 cycle: a bundle accepted at edge N is visible on the outputs after edge N.
- Throughput 1 bundle/cycle while `out_ready=1`.
- Without skid, `in_ready = out_ready | ~out_valid` (combinational path from `out_ready`).
- With skid, `in_ready` is a flop, `= ~skid_valid`. On stall, one extra bundle lands in the skid entry.
  - Skid drains into the main register on the first cycle `out_ready=1`, with no bubble.
  - `in_ready` returns to 1 on the edge after the drain.
- Simultaneous emit and accept with skid empty: main register reloads directly, and the skid stays empty.

## Configuration
- `OPCODE_DECODE_SKID_EN` defined:
  - two-entry (main + skid) storage;
  - registered `in_ready`;
  - no combinational `out_ready`→`in_ready` path.
- Undefined:
  - single register;
  - combinational `in_ready` as above;
  - no skid state exists.
- Both configurations produce identical output sequences for identical accepted inputs.

## Structure
- Shared package holds:
  - `SRC_OP`/`SRC_FUNC` constants;
  - the opfunc typedef (7 bits);
  - op/func field offsets;
  - `OPFUNC_W = 7`.
- Sub-module `opcode_lane_decode`: purely combinational, one 32-bit word plus mask bit → 7-bit opfunc. Instantiated `LANES` times via generate.
- Top level owns the handshake, main/skid registers and flush logic.

## Test plan
- Reset released, `LANES=2`, `in_inst={32'h8C820004, 32'h00851021}`, mask `2'b11`, `in_pc=32'h400` → one cycle later `out_opfunc={7'h63, 7'h21}`, `out_pc=32'h400`, `out_valid=1`.
- `in_inst=32'h00000000` (nop), mask=1 → opfunc `7'h00`. Same word with mask=0 → opfunc `7'h00`, `out_mask=0`.
- Hold `out_ready=0` for 5 cycles with `in_valid=1` streaming → outputs stable.
  - With skid: exactly 2 bundles held and `in_ready=0` from the 2nd cycle.
  - Without skid: 1 bundle held and `in_ready=0`.
- Stream 100 bundles with `out_ready=1` → 100 outputs in order, no bubbles, after the first-cycle latency.
- Assert `flush` while `out_valid=1`, skid full, `in_valid=1` → next cycle `out_valid=0`, skid empty, flushed input never appears.
- Assert `reset` asynchronously mid-stream → all outputs 0 immediately, `in_ready=1`. First bundle after release decodes correctly.
